// File: rtl/fetch_unit_if.sv
// Instruction-memory read port between the fetch unit and its memory.
// One request is held until the memory acknowledges with a data word.
interface fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_unit.sv
// Two-state instruction fetch unit: fetch a word, present it to the decoder for one
// cycle, then compute the next PC (sequential, branch, jump, register or exception).
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_4180
) (
  input  logic                clk,
  input  logic                rstn,
  fetch_unit_if.master        imem,
  output logic [31:0]         instr,
  output logic                nop,
  input  logic [2:0]          npc_op,
  input  logic [31:0]         rs_data,
  output logic [31:0]         pc_out,
  output logic [31:0]         pc_plus4,
  output logic [31:0]         epc,
  output logic                exc
);

  localparam logic [2:0] NpcPlus4  = 3'd0;
  localparam logic [2:0] NpcBranch = 3'd1;
  localparam logic [2:0] NpcJump   = 3'd2;
  localparam logic [2:0] NpcJr     = 3'd3;

  typedef enum logic [0:0] {S_FETCH, S_EXEC} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] epc_q, epc_d;
  logic        exc_q, exc_d;
  logic        take_exc;
  logic [31:0] br_offset;

  assign pc_plus4  = pc_q + 32'd4;
  assign br_offset = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    epc_d    = epc_q;
    exc_d    = 1'b0;
    take_exc = 1'b0;
    case (state_q)
      S_FETCH: begin
        if (imem.imem_ack) begin
          instr_d = imem.imem_rdata;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        state_d = S_FETCH;
        case (npc_op)
          NpcPlus4:  pc_d = pc_plus4;
          NpcBranch: pc_d = pc_plus4 + br_offset;
          NpcJump:   pc_d = {pc_plus4[31:28], instr_q[25:0], 2'b00};
          NpcJr: begin
            if (rs_data[1:0] != 2'b00) begin
              take_exc = 1'b1;
            end else begin
              pc_d = rs_data;
            end
          end
          // EXCEPT and the reserved encodings all trap
          default:   take_exc = 1'b1;
        endcase
        if (take_exc) begin
          epc_d = pc_q;
          pc_d  = EXC_VECTOR;
          exc_d = 1'b1;
        end
      end
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC;
      instr_q <= 32'd0;
      epc_q   <= 32'd0;
      exc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      epc_q   <= epc_d;
      exc_q   <= exc_d;
    end
  end

  // Gate with rstn so no request is issued while reset is held
  assign imem.imem_req  = rstn && (state_q == S_FETCH);
  assign imem.imem_addr = pc_q;
  assign nop            = !rstn || (state_q != S_EXEC);
  assign instr          = instr_q;
  assign pc_out         = pc_q;
  assign epc            = epc_q;
  assign exc            = exc_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: the bench plays memory and decoder, tracks the
// expected PC/EPC itself and scoreboards each fetched word against the decoded output.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [31:0] instr, rs_data, pc_out, pc_plus4, epc;
  logic        nop, exc;
  logic [2:0]  npc_op;

  always #5 clk = ~clk;

  fetch_unit_if imem ();

  fetch_unit #(
    .RESET_PC   (32'h0000_3000),
    .EXC_VECTOR (32'h0000_4180)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .imem     (imem),
    .instr    (instr),
    .nop      (nop),
    .npc_op   (npc_op),
    .rs_data  (rs_data),
    .pc_out   (pc_out),
    .pc_plus4 (pc_plus4),
    .epc      (epc),
    .exc      (exc)
  );

  typedef struct packed {
    logic [31:0] word;
    logic [31:0] pc;
  } exp_t;

  exp_t        sb[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] m_pc, m_epc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // One full fetch/exec round; all sampling and driving happens at negedge.
  task automatic do_instr(input logic [31:0] data, input int delay, input logic [2:0] op,
                          input logic [31:0] rs, input bit exec_ack);
    exp_t        e;
    logic [31:0] nxt, seq;
    bit          x;
    int          waited;
    waited = 0;
    while (imem.imem_req !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check("req", imem.imem_req, 1);
    check("addr", imem.imem_addr, m_pc);
    check("fetch_nop", nop, 1);
    for (int i = 0; i < delay; i++) begin
      @(negedge clk);
      check("addr_hold", imem.imem_addr, m_pc);
      check("req_hold", imem.imem_req, 1);
      check("pc_hold", pc_out, m_pc);
    end
    imem.imem_ack   = 1'b1;
    imem.imem_rdata = data;
    sb.push_back('{word: data, pc: m_pc});
    @(negedge clk);
    imem.imem_ack   = exec_ack;
    imem.imem_rdata = 32'hDEAD_BEEF;
    npc_op          = op;
    rs_data         = rs;
    check("exec_nop", nop, 0);
    check("exec_req", imem.imem_req, 0);
    if (sb.size() == 0) begin
      check("sb_empty", 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      check("instr", instr, e.word);
      check("pc_out", pc_out, e.pc);
      check("pc_plus4", pc_plus4, e.pc + 32'd4);
    end
    x   = 1'b0;
    seq = m_pc + 32'd4;
    nxt = seq;
    case (op)
      3'd0: nxt = seq;
      3'd1: nxt = seq + {{14{data[15]}}, data[15:0], 2'b00};
      3'd2: nxt = {seq[31:28], data[25:0], 2'b00};
      3'd3: begin
        if (rs[1:0] != 2'b00) x = 1'b1;
        else nxt = rs;
      end
      default: x = 1'b1;
    endcase
    if (x) begin
      m_epc = m_pc;
      nxt   = 32'h0000_4180;
    end
    m_pc = nxt;
    @(negedge clk);
    imem.imem_ack = 1'b0;
    npc_op        = 3'd0;
    check("exc", exc, x);
    check("epc", epc, m_epc);
    check("next_addr", imem.imem_addr, m_pc);
    check("next_nop", nop, 1);
    check("instr_held", instr, data);
    if (x) begin
      @(negedge clk);
      check("exc_pulse_end", exc, 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    imem.imem_ack   = 1'b0;
    imem.imem_rdata = 32'd0;
    npc_op          = 3'd0;
    rs_data         = 32'd0;
    rstn            = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_nop", nop, 1);
    check("rst_req", imem.imem_req, 0);
    check("rst_pc", pc_out, 32'h0000_3000);
    check("rst_instr", instr, 0);
    check("rst_epc", epc, 0);
    check("rst_exc", exc, 0);
    rstn  = 1'b1;
    m_pc  = 32'h0000_3000;
    m_epc = 32'd0;

    do_instr(32'h2008_0005, 2, 3'd0, 32'd0, 1'b0);           // 3000 -> 3004, slow ack
    do_instr(32'h0000_0020, 0, 3'd0, 32'd0, 1'b0);           // 3004 -> 3008, back-to-back
    do_instr(32'h0000_000C, 1, 3'd4, 32'd0, 1'b0);           // EXCEPT at 3008
    do_instr(32'h0000_0008, 0, 3'd3, 32'h0000_3010, 1'b0);   // JR to 3010
    do_instr(32'h1000_FFFC, 0, 3'd1, 32'd0, 1'b0);           // branch back -> 3004
    do_instr(32'h0000_0008, 0, 3'd3, 32'h0000_3010, 1'b1);   // JR 3010, stray ack in exec
    do_instr(32'h1000_0003, 0, 3'd1, 32'd0, 1'b0);           // branch fwd -> 3020
    do_instr(32'h0000_0008, 0, 3'd3, 32'h0000_3042, 1'b0);   // misaligned JR traps
    do_instr(32'h0000_0008, 0, 3'd3, 32'hF000_3000, 1'b0);
    do_instr(32'h0800_0100, 2, 3'd2, 32'd0, 1'b0);           // jump -> F000_0400
    do_instr(32'h0000_0008, 0, 3'd3, 32'hFFFF_FFFC, 1'b0);
    do_instr(32'h0000_0000, 0, 3'd0, 32'd0, 1'b1);           // wraps to 0
    do_instr(32'h0000_0000, 0, 3'd5, 32'd0, 1'b0);           // reserved op traps
    do_instr(32'h0000_0008, 0, 3'd3, 32'h0000_3040, 1'b0);
    do_instr(32'h0000_0008, 0, 3'd3, 32'h0000_3000, 1'b0);
    do_instr(32'h2008_0005, 0, 3'd0, 32'd0, 1'b0);           // now fetching 3004

    // Reset collides with the ack of the 3004 fetch
    check("pre_rst_addr", imem.imem_addr, 32'h0000_3004);
    imem.imem_ack   = 1'b1;
    imem.imem_rdata = 32'h1234_5678;
    rstn            = 1'b0;
    @(negedge clk);
    imem.imem_ack = 1'b0;
    check("col_instr", instr, 0);
    check("col_pc", pc_out, 32'h0000_3000);
    check("col_nop", nop, 1);
    check("col_req", imem.imem_req, 0);
    check("col_epc", epc, 0);
    rstn  = 1'b1;
    m_pc  = 32'h0000_3000;
    m_epc = 32'd0;
    do_instr(32'h2008_0005, 1, 3'd0, 32'd0, 1'b0);
    check("sb_drained", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_3000, is the first fetch address after reset.
REQ-002 Parameter EXC_VECTOR, default 32'h0000_4180, is the fetch address after any exception.
REQ-003 Port clk, input, 1, is the single clock; all state changes on its rising edge.
REQ-004 Port rstn, input, 1, is the reset: synchronous and active-low.
REQ-005 Port imem_req, output, 1, is the instruction memory read request.
REQ-006 Port imem_addr, output, 32, is the instruction memory word address (byte address, low 2 bits 0).
REQ-007 Port imem_ack, input, 1, means imem_rdata is valid this cycle.
REQ-008 Port imem_rdata, input, 32, is the fetched instruction word.
REQ-009 Port instr, output, 32, is the instruction presented to the decoder (opcode/funct/rt are taken from it).
REQ-010 Port nop, output, 1, means instr is not valid; it drives the decoder nop input.
REQ-011 Port npc_op, input, 3, is the decoder next-PC select: 0 PLUS4, 1 BRANCH, 2 JUMP, 3 JR, 4 EXCEPT; 5-7 are reserved.
REQ-012 Port rs_data, input, 32, is the GPR rs value and serves as the JR target.
REQ-013 Port pc_out, output, 32, is the PC of the current instruction.
REQ-014 Port pc_plus4, output, 32, is pc_out+4 and serves as the JAL link value.
REQ-015 Port epc, output, 32, is the PC of the last excepting instruction.
REQ-016 Port exc, output, 1, is a one-cycle pulse when an exception is taken.

Function
REQ-017 The FSM SHALL have states S_FETCH and S_EXEC.
REQ-018 In S_FETCH: imem_req=1, imem_addr=pc, nop=1; hold addr and req stable until imem_ack; on ack latch imem_rdata into instr and go to S_EXEC.
REQ-019 In S_EXEC: imem_req=0, nop=0 for exactly one cycle; npc_op is sampled this cycle; always go to S_FETCH next.
REQ-020 Next PC rules (in S_EXEC only):
- PLUS4 -> pc+4.
- BRANCH -> pc+4+(sign-extend(instr[15:0])<<2).
- JUMP -> {(pc+4)[31:28], instr[25:0], 2'b00}.
- JR -> rs_data.
REQ-021 npc_op EXCEPT, a reserved npc_op value, or a JR with rs_data[1:0]!=0 SHALL set epc<=pc, pc<=EXC_VECTOR and pulse exc for one cycle in the following cycle.
REQ-022 All PC arithmetic SHALL be modulo 2^32 (32'hFFFF_FFFC+4 -> 0); the branch offset SHALL be sign-extended to 32 bits before the add.
REQ-023 pc and instr SHALL NOT change while in S_FETCH awaiting ack; pc_plus4 SHALL be combinational from pc.
REQ-024 imem_ack while in S_EXEC SHALL be ignored.
REQ-025 Minimum throughput SHALL be one instruction per 2 cycles (ack in the cycle req rises).

Reset
REQ-026 While rstn=0 at a clock edge, the block SHALL set: state S_FETCH, pc=RESET_PC, instr=0, epc=0, exc=0.
REQ-027 Outputs during reset SHALL be nop=1 and imem_req=0.
REQ-028 Reset SHALL take priority over imem_ack and npc_op in the same cycle.
REQ-029 A fetch in flight when reset asserts SHALL be abandoned and its data discarded.

Verification
REQ-030 Release rstn, ack after 3 cycles with 32'h2008_0005, npc_op=0 -> imem_addr=32'h3000 held 3 cycles; instr=32'h2008_0005 with nop=0 for 1 cycle; next imem_addr=32'h3004.
REQ-031 At pc=32'h3010, npc_op=1, instr[15:0]=16'hFFFC -> next pc=32'h3004; with 16'h0003 -> next pc=32'h3020.
REQ-032 At pc=32'hF000_3000, npc_op=2, instr[25:0]=26'h0000100 -> next pc=32'hF000_0400.
REQ-033 npc_op=3: rs_data=32'h3040 -> pc=32'h3040; rs_data=32'h3042 -> exc pulse, epc=current pc, pc=32'h4180.
REQ-034 npc_op=4 at pc=32'h3008 -> epc=32'h3008, imem_addr=32'h4180, exc high for exactly 1 cycle.
REQ-035 rstn=0 in the same cycle as imem_ack during the fetch of 32'h3004 -> instr=0, pc=32'h3000, nop=1; the first fetch after release is 32'h3000.
